// File: rtl/rv_mem_alu_datapath.sv
// Execute-path slice: word-addressed instruction memory feeding an RV32I R-type
// decoder and ALU. The operands are the rs2/rs1 index fields of the fetched word.
module rv_mem_alu_datapath #(
  parameter int N        = 32,
  parameter int I_LENGTH = 1024,
  parameter int D_LENGTH = 0
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         wr_ena0,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] din0,
  output logic [N-1:0] instr,
  output logic [3:0]   alu_funct,
  output logic [N-1:0] c
);

  localparam int unsigned DEPTH = I_LENGTH + D_LENGTH;
  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // ---------------------------------------------------------------------------
  // Memory port 0: synchronous read-first RAM with range-checked access
  // ---------------------------------------------------------------------------
  logic [N-1:0]  mem [DEPTH];
  logic          in_range;
  logic [AW-1:0] idx;

  assign in_range = (addr0 < N'(DEPTH));
  assign idx      = addr0[AW-1:0];

  // NOTE: the array has no reset so it maps onto block RAM; reset only gates writes.
  always_ff @(posedge clk) begin
    if (!rstb && wr_ena0 && in_range) begin
      mem[idx] <= din0;
    end
  end

  // NOTE: non-blocking assignment here keeps the read returning the pre-write word.
  always_ff @(posedge clk) begin
    if (rstb) begin
      instr <= '0;
    end else if (in_range) begin
      instr <= mem[idx];
    end else begin
      instr <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode: funct3 selects the operation, funct7[5] (instr[30]) picks SUB/SRA
  // ---------------------------------------------------------------------------
  logic [2:0] funct3;
  logic       funct7_b5;
  alu_op_e    op;

  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];

  // NOTE: op gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    op = ALU_ADD;
    unique case (funct3)
      3'b000: op = funct7_b5 ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
  end

  assign alu_funct = op;

  // ---------------------------------------------------------------------------
  // ALU: operands are the zero-extended register-index fields
  // ---------------------------------------------------------------------------
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [4:0]   shamt;
  logic         lt_signed;
  logic         lt_unsigned;

  assign a           = {{(N-5){1'b0}}, instr[24:20]};
  assign b           = {{(N-5){1'b0}}, instr[19:15]};
  assign shamt       = b[4:0];
  assign lt_signed   = ($signed(a) < $signed(b));
  assign lt_unsigned = (a < b);

  always_comb begin
    c = '0;
    case (alu_funct)
      ALU_ADD:  c = a + b;
      ALU_SUB:  c = a - b;
      ALU_SLL:  c = a << shamt;
      ALU_SLT:  c = {{(N-1){1'b0}}, lt_signed};
      ALU_SLTU: c = {{(N-1){1'b0}}, lt_unsigned};
      ALU_XOR:  c = a ^ b;
      ALU_SRL:  c = a >> shamt;
      ALU_SRA:  c = $unsigned($signed(a) >>> shamt);
      ALU_OR:   c = a | b;
      ALU_AND:  c = a & b;
      default:  c = '0;
    endcase
  end

endmodule

// File: tb/tb_rv_mem_alu_datapath.sv
// Directed bench for rv_mem_alu_datapath: reset, memory edges, decode and ALU
// results with hand-computed expectations.
module tb_rv_mem_alu_datapath;

  logic        clk = 1'b0;
  logic        rstb;
  logic        wr_ena0;
  logic [31:0] addr0;
  logic [31:0] din0;
  logic [31:0] instr;
  logic [3:0]  alu_funct;
  logic [31:0] c;

  int checks   = 0;
  int failures = 0;

  rv_mem_alu_datapath #(.N(32), .I_LENGTH(1024), .D_LENGTH(0)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .wr_ena0   (wr_ena0),
    .addr0     (addr0),
    .din0      (din0),
    .instr     (instr),
    .alu_funct (alu_funct),
    .c         (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic rst, input logic we, input logic [31:0] addr,
                     input logic [31:0] data);
    rstb    = rst;
    wr_ena0 = we;
    addr0   = addr;
    din0    = data;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc(1'b0, 1'b1, addr, data);
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(1'b0, 1'b0, addr, 32'h0);
  endtask

  // Streamed read table: address, expected instr, alu_funct, c.
  logic [31:0] s_addr  [9];
  logic [31:0] s_instr [9];
  logic [3:0]  s_funct [9];
  logic [31:0] s_c     [9];

  initial begin
    // a = instr[24:20], b = instr[19:15]
    s_addr[0] = 0;  s_instr[0] = 32'h00A28033; s_funct[0] = 4'd0; s_c[0] = 32'd15;   // 10+5
    s_addr[1] = 1;  s_instr[1] = 32'h40A28033; s_funct[1] = 4'd1; s_c[1] = 32'd5;    // 10-5
    s_addr[2] = 2;  s_instr[2] = 32'h00A29033; s_funct[2] = 4'd2; s_c[2] = 32'h140;  // 10<<5
    s_addr[3] = 3;  s_instr[3] = 32'h0073A033; s_funct[3] = 4'd3; s_c[3] = 32'd0;    // 7<7
    s_addr[4] = 4;  s_instr[4] = 32'h0033A033; s_funct[4] = 4'd3; s_c[4] = 32'd1;    // 3<7
    s_addr[5] = 8;  s_instr[5] = 32'h00C54033; s_funct[5] = 4'd5; s_c[5] = 32'd6;    // 12^10
    s_addr[6] = 9;  s_instr[6] = 32'h00C56033; s_funct[6] = 4'd8; s_c[6] = 32'd14;   // 12|10
    s_addr[7] = 10; s_instr[7] = 32'h00C57033; s_funct[7] = 4'd9; s_c[7] = 32'd8;    // 12&10
    s_addr[8] = 11; s_instr[8] = 32'h00C53033; s_funct[8] = 4'd4; s_c[8] = 32'd0;    // 12<u10
  end

  initial begin
    rstb = 1'b1; wr_ena0 = 1'b0; addr0 = '0; din0 = '0;

    // Power-on reset
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0);
    check("reset_instr", instr, 32'h0);
    check("reset_funct", {28'h0, alu_funct}, 32'h0);
    check("reset_c", c, 32'h0);

    // Preload program
    for (int i = 0; i < 9; i++) wr(s_addr[i], s_instr[i]);
    wr(6, 32'h40A2D033);
    wr(7, 32'h00A2D033);
    wr(1023, 32'h12345678);

    // Reset again with a write attempt that must be blocked
    cyc(1'b1, 1'b1, 7, 32'hDEADBEEF);
    cyc(1'b1, 1'b1, 7, 32'hDEADBEEF);
    check("reset2_instr", instr, 32'h0);
    check("reset2_c", c, 32'h0);

    rd(7);
    check("srl_instr_kept", instr, 32'h00A2D033);
    check("srl_funct", {28'h0, alu_funct}, 32'd6);
    check("srl_c", c, 32'd0);
    rd(6);
    check("sra_funct", {28'h0, alu_funct}, 32'd7);
    check("sra_c", c, 32'd0);

    // Back-to-back stream, one new address per cycle
    for (int i = 0; i < 9; i++) begin
      rd(s_addr[i]);
      check($sformatf("stream%0d_instr", i), instr, s_instr[i]);
      check($sformatf("stream%0d_funct", i), {28'h0, alu_funct}, {28'h0, s_funct[i]});
      check($sformatf("stream%0d_c", i), c, s_c[i]);
    end

    // Address boundaries
    rd(1023);
    check("top_addr", instr, 32'h12345678);
    rd(1024);
    check("oor_read", instr, 32'h0);
    wr(1024, 32'hCAFEF00D);
    rd(0);
    check("oor_write_ignored", instr, 32'h00A28033);

    // Read-first collision at address 5
    wr(5, 32'h11111111);
    wr(5, 32'h22222222);
    check("rdw_old", instr, 32'h11111111);
    rd(5);
    check("rdw_new", instr, 32'h22222222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
